// File: rtl/ifu_pc_gen_if.sv
// Fetch request / response handshake between the PC generator (master)
// and the I-side memory interface (slave).
interface ifu_pc_gen_if #(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 2,
  parameter int EPOCH_W = 2
);
  logic               req_vld;
  logic               req_rdy;
  logic [XLEN-1:0]    req_addr;
  logic [FETCH_W-1:0] req_mask;
  logic [EPOCH_W-1:0] req_epoch;
  logic               resp_vld;

  modport master (
    output req_vld, req_addr, req_mask, req_epoch,
    input  req_rdy, resp_vld
  );

  modport slave (
    input  req_vld, req_addr, req_mask, req_epoch,
    output req_rdy, resp_vld
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// Fetch-PC generator: redirect arbitration, epoch tagging and credit-limited
// request issue. Define IFU_PC_STATS_EN to add fire/redirect statistics counters.
module ifu_pc_gen #(
  parameter int              XLEN       = 32,
  parameter int              FETCH_W    = 2,
  parameter int              INFLIGHT   = 4,
  parameter int              EPOCH_W    = 2,
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_addr,
  input  logic            i_replay,
  input  logic [XLEN-1:0] i_replay_addr,
  input  logic            i_bp_redir,
  input  logic [XLEN-1:0] i_bp_addr,
  ifu_pc_gen_if.master    req_if,
`ifdef IFU_PC_STATS_EN
  output logic [31:0]     o_stat_req,
  output logic [31:0]     o_stat_redir,
`endif
  output logic            o_err
);

  localparam int              OFF_W     = $clog2(FETCH_W);
  localparam int              CNT_W     = $clog2(INFLIGHT + 1);
  localparam logic [XLEN-1:0] GRP_BYTES = XLEN'(4 * FETCH_W);

  typedef enum logic {BOOT, RUN} state_e;

  state_e             state_q;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               take_redir;
  logic [XLEN-1:0]    tgt;
  logic [XLEN-1:0]    addr_c;
  logic [FETCH_W-1:0] mask_c;
  logic               vld_c;
  logic               fire;

  always_comb begin
    // Redirects are only honoured once BOOT has elapsed.
    take_redir = (state_q == RUN) & (i_flush | i_replay | i_bp_redir);

    if (i_flush)       tgt = i_flush_addr;
    else if (i_replay) tgt = i_replay_addr;
    else               tgt = i_bp_addr;
    tgt[1:0] = '0;

    addr_c  = take_redir ? tgt : pc_q;
    epoch_d = take_redir ? epoch_q + 1'b1 : epoch_q;
    vld_c   = (state_q == RUN) & ~i_stall & (cnt_q < CNT_W'(INFLIGHT));
    fire    = vld_c & req_if.req_rdy;

    // Fire wins over a pending redirect: the redirect target is what just fired.
    if (fire)            pc_d = (addr_c & ~(GRP_BYTES - 1'b1)) + GRP_BYTES;
    else if (take_redir) pc_d = tgt;
    else                 pc_d = pc_q;

    cnt_d = cnt_q;
    err_d = err_q;
    if (req_if.resp_vld && cnt_q == '0) err_d = 1'b1;
    if (fire && !req_if.resp_vld)                            cnt_d = cnt_q + 1'b1;
    else if (!fire && req_if.resp_vld && cnt_q != '0)        cnt_d = cnt_q - 1'b1;
  end

  generate
    if (FETCH_W == 1) begin : g_mask_one
      assign mask_c = '1;
    end else begin : g_mask_multi
      always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < FETCH_W; i++)
          mask_c[i] = (OFF_W'(i) >= addr_c[OFF_W+1:2]);
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      epoch_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= RUN;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef IFU_PC_STATS_EN
  logic [31:0] stat_req_q, stat_redir_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stat_req_q   <= '0;
      stat_redir_q <= '0;
    end else begin
      stat_req_q   <= stat_req_q + {31'b0, fire};
      stat_redir_q <= stat_redir_q + {31'b0, take_redir};
    end
  end

  assign o_stat_req   = stat_req_q;
  assign o_stat_redir = stat_redir_q;
`endif

  assign req_if.req_vld   = vld_c;
  assign req_if.req_addr  = addr_c;
  assign req_if.req_mask  = mask_c;
  assign req_if.req_epoch = epoch_d;
  assign o_err            = err_q;

endmodule

// File: doc/ifu_pc_gen.md
Name: ifu_pc_gen

Overview:
- Parametrised fetch-PC generator for the IFU. Issues one aligned fetch-group request per cycle to the I-side memory interface over a valid/ready handshake.
- Arbitrates three redirect sources: backend flush, decode replay and branch-predictor redirect.
- Tags each request with an epoch so downstream logic can discard stale responses.
- Limits outstanding requests so the fetch FIFO never overflows.

Parameters:
- XLEN, 32, address width.
- FETCH_W, 2, instructions per fetch group; power of 2, 1..8.
- INFLIGHT, 4, maximum outstanding (issued, unanswered) requests; 1..15.
- EPOCH_W, 2, epoch tag width.
- RESET_ADDR, 32'h8000_0000, first fetch address.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset
- i_stall  in  1  backend stall; blocks new requests, redirects still accepted
- i_flush  in  1  backend redirect (exception/mispredict), highest priority
- i_flush_addr  in  XLEN  flush target
- i_replay  in  1  decode rejected a group; refetch from i_replay_addr
- i_replay_addr  in  XLEN  replay target
- i_bp_redir  in  1  predictor-taken redirect, lowest priority
- i_bp_addr  in  XLEN  predicted target
- o_req_vld  out  1  fetch request valid
- i_req_rdy  in  1  memory accepts request
- o_req_addr  out  XLEN  request address (instruction-aligned, not group-aligned)
- o_req_mask  out  FETCH_W  valid instruction slots in the group
- o_req_epoch  out  EPOCH_W  epoch tag of the request
- i_resp_vld  in  1  one response returned (retires one outstanding)
- o_err  out  1  sticky: response received with zero outstanding

Behaviour:
- Reset (asynchronous, active-low i_rstn; clock i_clk):
  - pc=RESET_ADDR, epoch=0, outstanding cnt=0, o_err=0.
  - FSM enters BOOT; o_req_vld=0.
  - If i_rstn is asserted mid-operation, all state returns to these values immediately; outstanding responses are forgotten.
- FSM:
  - BOOT -> RUN after exactly one cycle; BOOT ignores all redirects.
  - RUN: normal operation. There is no other state.
- Redirect selection: redir = i_flush | i_replay | i_bp_redir.
  - Target priority: flush > replay > bp.
  - Exactly one target is chosen per cycle.
- Epoch: increments by 1, mod 2^EPOCH_W, in every RUN cycle where redir=1, regardless of how many sources are asserted.
- Request valid: o_req_vld = RUN & ~i_stall & (cnt < INFLIGHT).
- Request address and epoch (combinational bypass):
  - If redir in this cycle: o_req_addr = selected target, o_req_epoch = epoch+1.
  - Otherwise: o_req_addr = pc, o_req_epoch = epoch.
- Mask: o_req_mask[i] = 1 iff i >= o_req_addr[log2(FETCH_W)+1:2]. With FETCH_W=1 the mask is always 1.
- fire = o_req_vld & i_req_rdy.
- PC update, priority order:
  - fire: pc <= (o_req_addr with bits [log2(FETCH_W)+1:0] cleared) + 4*FETCH_W, wrapping mod 2^XLEN.
  - else redir: pc <= selected target, so the redirect is held until fired.
  - else: hold.
- Outstanding counter:
  - cnt += fire; cnt -= i_resp_vld; both in the same cycle leaves cnt unchanged.
  - i_resp_vld with cnt=0 leaves cnt=0 and sets o_err.
  - Redirects do not clear cnt; stale responses still return and are dropped downstream by epoch.
- Latency: a redirect is visible on o_req_addr in the same cycle; a sequential next group appears the cycle after fire.
- Address bits [1:0] of any target are ignored and treated as 0.

Optional Feature:
- Macro: IFU_PC_STATS_EN.
- Defined: adds outputs o_stat_req (32-bit count of fires) and o_stat_redir (32-bit count of redirect cycles).
  - Both reset to 0, wrap at 2^32, and are readable every cycle.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Boot: FETCH_W=2, rdy=1, no redirects -> o_req_vld=0 in the first cycle after reset; then addresses 0x80000000, 0x80000008, 0x80000010, mask 2'b11, epoch 0.
- Unaligned redirect: i_bp_redir to 0x80000104 with rdy=1 -> same cycle addr 0x80000104, mask 2'b10, epoch 1; next cycle addr 0x80000108, mask 2'b11.
- Simultaneous sources: i_flush 0x100 + i_replay 0x200 + i_bp_redir 0x300 in one cycle -> addr 0x100, epoch increments by exactly 1.
- Credit limit: INFLIGHT=4, rdy=1, no responses -> 4 fires, then o_req_vld=0; one i_resp_vld -> o_req_vld=1 next cycle. i_resp_vld with cnt=0 -> o_err=1 and sticky.
- Held redirect: rdy=0, then redirect to 0x300, rdy=1 three cycles later -> o_req_addr holds 0x300 for all four cycles, epoch increments once; stall during this window drops o_req_vld, but addr stays 0x300.
- Reset mid-run with cnt=3, epoch=2 -> immediate pc=0x80000000, cnt=0, epoch=0, o_req_vld=0; BOOT cycle repeats. With IFU_PC_STATS_EN, o_stat_req is 0 after reset.
